// File: rtl/xor_gate.sv
// Registered XOR with parity, Hamming distance and capture-valid outputs.
// Optional saturating difference accumulator cnt_q, enabled by defining XOR_GATE_DIFFCNT_EN.
module xor_gate #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned HD_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             par_q,
    output logic [HD_W-1:0]  hd_q,
    output logic             vld_q
`ifdef XOR_GATE_DIFFCNT_EN
    ,
    output logic [CNT_W-1:0] cnt_q
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("xor_gate: WIDTH must be in 1..64");
    end
    if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
        $error("xor_gate: CNT_W must be in 4..32");
    end

    logic [WIDTH-1:0] diff;
    logic [HD_W-1:0]  hd;

    assign diff = a ^ b;
    assign y    = diff;

    always_comb begin
        hd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hd = hd + HD_W'(diff[i]);
        end
    end

    // Hold path never reads a/b, so unknowns on the inputs cannot leak in while en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            par_q <= 1'b0;
            hd_q  <= '0;
            vld_q <= 1'b0;
        end else if (en) begin
            y_q   <= diff;
            par_q <= ^diff;
            hd_q  <= hd;
            vld_q <= 1'b1;
        end else begin
            vld_q <= 1'b0;
        end
    end

`ifdef XOR_GATE_DIFFCNT_EN
    // One spare bit above the wider operand catches overflow for saturation.
    localparam int unsigned SUM_W = ((CNT_W > HD_W) ? CNT_W : HD_W) + 1;

    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_sum = SUM_W'(cnt_q) + SUM_W'(hd);
        cnt_d   = (|cnt_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: directed scenarios plus randomized run against a model.
module tb_xor_gate;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] a8, b8;
    logic       a1, b1;

    logic [7:0] y8, y8_q;
    logic       par8_q, vld8_q;
    logic [3:0] hd8_q;
    logic       y1, y1_q, par1_q, vld1_q;
    logic [0:0] hd1_q;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected state derived from the behavioural rules
    logic [7:0] m_y;
    int         m_hd;
    logic       m_par, m_vld, m1_y;
    int         m_cnt16, m_cnt4;

    assign a1 = a8[0];
    assign b1 = b8[0];

    always #5 clk = ~clk;

`ifdef XOR_GATE_DIFFCNT_EN
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
    logic [7:0]  yc, yc_q;
    logic        parc_q, vldc_q;
    logic [3:0]  hdc_q;
`endif

    xor_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .en(en),
        .y(y8), .y_q(y8_q), .par_q(par8_q), .hd_q(hd8_q), .vld_q(vld8_q)
`ifdef XOR_GATE_DIFFCNT_EN
        , .cnt_q(cnt16)
`endif
    );

    xor_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .en(en),
        .y(y1), .y_q(y1_q), .par_q(par1_q), .hd_q(hd1_q), .vld_q(vld1_q)
`ifdef XOR_GATE_DIFFCNT_EN
        , .cnt_q()
`endif
    );

`ifdef XOR_GATE_DIFFCNT_EN
    xor_gate #(.WIDTH(8), .CNT_W(4)) dutc (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .en(en),
        .y(yc), .y_q(yc_q), .par_q(parc_q), .hd_q(hdc_q), .vld_q(vldc_q), .cnt_q(cnt4)
    );
`endif

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (v[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    function automatic int sat_add(input int acc, input int inc, input int lim);
        return (acc + inc > lim) ? lim : acc + inc;
    endfunction

    task automatic model_reset();
        m_y = '0; m_hd = 0; m_par = 1'b0; m_vld = 1'b0; m1_y = 1'b0;
        m_cnt16 = 0; m_cnt4 = 0;
    endtask

    // Called right at a rising edge, with the inputs that edge samples
    task automatic model_clock();
        logic [7:0] d;
        if (!rst) begin
            if (en) begin
                d = a8 ^ b8;
                m_y = d; m_hd = ones(d); m_par = (m_hd % 2) == 1; m_vld = 1'b1;
                m1_y = d[0];
                m_cnt16 = sat_add(m_cnt16, m_hd, 65535);
                m_cnt4  = sat_add(m_cnt4, m_hd, 15);
            end else begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; a8 = '0; b8 = '0;
        model_reset();
        #2;
        n_cmp++;
        if ({y8_q, par8_q, hd8_q, vld8_q, y1_q, par1_q, hd1_q, vld1_q} !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: got y_q=%h par=%b hd=%0d vld=%b (w1 %b%b%b%b), want all 0",
                     y8_q, par8_q, hd8_q, vld8_q, y1_q, par1_q, hd1_q, vld1_q);
        end
    endtask

    task automatic test_comb_w1();
        logic [1:0] pat [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic       exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            a8 = {7'h0, pat[i][1]}; b8 = {7'h0, pat[i][0]};
            #10;
            n_cmp++;
            if (y1 !== exp[i]) begin
                n_bad++;
                $display("FAIL comb_w1 ab=%b: got y=%b want %b", pat[i], y1, exp[i]);
            end
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
        cycle();
        n_cmp++;
        if (y8_q !== 8'hCC || par8_q !== 1'b0 || hd8_q !== 4'd4 || vld8_q !== 1'b1) begin
            n_bad++;
            $display("FAIL load_f0_3c: got y_q=%h par=%b hd=%0d vld=%b want cc 0 4 1",
                     y8_q, par8_q, hd8_q, vld8_q);
        end
        n_cmp++;
        if (y1_q !== 1'b0 || par1_q !== 1'b0 || hd1_q !== 1'b0 || vld1_q !== 1'b1) begin
            n_bad++;
            $display("FAIL load_w1: got y_q=%b par=%b hd=%0d vld=%b want 0 0 0 1",
                     y1_q, par1_q, hd1_q, vld1_q);
        end
    endtask

    task automatic test_hold();
        en = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        cycle();
        n_cmp++;
        if (par1_q !== 1'b1 || hd1_q !== 1'b1 || y1_q !== 1'b1) begin
            n_bad++;
            $display("FAIL w1_consistent: got y_q=%b par=%b hd=%0d want 1 1 1", y1_q, par1_q, hd1_q);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            cycle();
            n_cmp++;
            if (y8_q !== 8'hFF || hd8_q !== 4'd8 || par8_q !== 1'b0 || vld8_q !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_%0d: got y_q=%h hd=%0d par=%b vld=%b want ff 8 0 0",
                         i, y8_q, hd8_q, par8_q, vld8_q);
            end
        end
        // Unknown operands while disabled must not disturb the held state
        a8 = 'x; b8 = 'z;
        cycle();
        n_cmp++;
        if (y8_q !== 8'hFF || hd8_q !== 4'd8 || vld8_q !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_xz: got y_q=%h hd=%0d vld=%b want ff 8 0", y8_q, hd8_q, vld8_q);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; a8 = 8'h5A; b8 = 8'h03;
        cycle();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({y8_q, par8_q, hd8_q, vld8_q} !== '0) begin
            n_bad++;
            $display("FAIL async_clear: got y_q=%h par=%b hd=%0d vld=%b want 0", y8_q, par8_q,
                     hd8_q, vld8_q);
        end
        model_reset();
        cycle();
        n_cmp++;
        if ({y8_q, par8_q, hd8_q, vld8_q} !== '0) begin
            n_bad++;
            $display("FAIL edge_in_reset: got y_q=%h vld=%b want 0", y8_q, vld8_q);
        end
        n_cmp++;
        if (y8 !== 8'h59) begin
            n_bad++;
            $display("FAIL comb_in_reset: got y=%h want 59", y8);
        end
        #2 rst = 1'b0;
        a8 = 8'h81; b8 = 8'h7F;
        cycle();
        n_cmp++;
        if (y8_q !== 8'hFE || par8_q !== 1'b1 || hd8_q !== 4'd7 || vld8_q !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_load: got y_q=%h par=%b hd=%0d vld=%b want fe 1 7 1",
                     y8_q, par8_q, hd8_q, vld8_q);
        end
    endtask

`ifdef XOR_GATE_DIFFCNT_EN
    task automatic test_sat();
        logic [3:0] exp [3] = '{4'd8, 4'd15, 4'd15};
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        en = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (cnt4 !== exp[i]) begin
                n_bad++;
                $display("FAIL cnt_sat_%0d: got cnt_q=%0d want %0d", i, cnt4, exp[i]);
            end
        end
        en = 1'b0;
        cycle();
        n_cmp++;
        if (cnt4 !== 4'd15 || cnt16 !== 16'd24) begin
            n_bad++;
            $display("FAIL cnt_hold: got cnt4=%0d cnt16=%0d want 15 24", cnt4, cnt16);
        end
    endtask
`endif

    task automatic test_random();
        bit hold;
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        hold = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rst && !hold) rst = 1'b0;
            hold = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                model_reset();
                hold = ($urandom_range(0, 1) == 1);
            end
            for (int ph = 0; ph < 2; ph++) begin
                if (ph == 0) #1;
                else cycle();
                n_cmp++;
                if (y8 !== (a8 ^ b8) || y8_q !== m_y || par8_q !== m_par ||
                    hd8_q !== 4'(m_hd) || vld8_q !== m_vld || y1 !== (a8[0] ^ b8[0]) ||
                    y1_q !== m1_y || par1_q !== m1_y || hd1_q !== m1_y || vld1_q !== m_vld
`ifdef XOR_GATE_DIFFCNT_EN
                    || cnt16 !== 16'(m_cnt16) || cnt4 !== 4'(m_cnt4)
`endif
                    ) begin
                    n_bad++;
                    $display("FAIL rand_%0d_%0d: got y=%h y_q=%h par=%b hd=%0d vld=%b w1=%b%b%b%b%b want y=%h y_q=%h par=%b hd=%0d vld=%b w1y_q=%b",
                             i, ph, y8, y8_q, par8_q, hd8_q, vld8_q, y1, y1_q, par1_q, hd1_q,
                             vld1_q, a8 ^ b8, m_y, m_par, m_hd, m_vld, m1_y);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb_w1();
        test_load();
        test_hold();
        test_async_reset();
`ifdef XOR_GATE_DIFFCNT_EN
        test_sat();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
